// File: rtl/bcd_multi_to_binary.sv
// bcd_multi_to_binary: iterative packed-BCD to unsigned binary converter.
// One digit per clock, MSD first; a non-decimal nibble raises out_err and zeroes the result.
module bcd_multi_to_binary #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DIGITS-1:0] bcd_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BIN_W-1:0]    out_bin,
  output logic                out_err
);

  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  state_t              state;
  logic [4*DIGITS-1:0] shreg;
  logic [BIN_W-1:0]    acc;
  logic                err;
  logic [CNT_W-1:0]    cnt;

  logic [3:0]          digit;
  logic                digit_bad;
  logic [BIN_W-1:0]    acc_x10;
  logic [BIN_W-1:0]    acc_next;
  logic                err_next;

  assign in_ready  = (state == IDLE) && !rst;
  assign digit     = shreg[4*DIGITS-1 -: 4];
  assign digit_bad = (digit > 4'd9);
  assign acc_x10   = (acc << 3) + (acc << 1);
  // An invalid nibble adds nothing; only err remembers it.
  assign acc_next  = acc_x10 + (digit_bad ? '0 : BIN_W'(digit));
  assign err_next  = err | digit_bad;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      acc       <= '0;
      err       <= 1'b0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_bin   <= '0;
      out_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          out_valid <= 1'b0;
          if (in_valid) begin
            shreg <= bcd_in;
            acc   <= '0;
            err   <= 1'b0;
            cnt   <= '0;
            state <= CONV;
          end
        end
        CONV: begin
          acc   <= acc_next;
          err   <= err_next;
          shreg <= shreg << 4;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            out_bin   <= err_next ? '0 : acc_next;
            out_err   <= err_next;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
